ysyx_210247_mem_stage: RTL and testbench
========================================

// Module: ysyx_210247_mem_stage
// PURPOSE
//  Memory-access pipeline stage between EX and WB. Holds one instruction in a pipeline register.
//  Issues at most one load/store on a simple req/ack data port and formats load data.
//  Emits the WB bus and drives a valid/allow_in handshake with WB; sources the MEM-stage forwarding path.
// PARAMETERS
//  XLEN    64   data/address width
//  BUS_W   403  EX->MEM and MEM->WB bus width; MSB->LSB fields: exc_type[64] exc_addr[64] exc_op[32]
//               csr_wen[1] csr_waddr[12] csr_wdata[64] pc[64] inst[32] wen[1] wdest[5] wdata[64]
// PORTS
//  clk              in   1      clock, rising edge
//  rst              in   1      asynchronous, active-low reset
//  ex_valid_out     in   1      EX holds a valid instruction
//  mem_allow_in     out  1      MEM accepts from EX this cycle
//  ex_to_mem_bus    in   BUS_W  EX payload; wdata field = ALU result / effective address
//  ex_mem_op        in   5      {is_load, is_store, unsigned, size[1:0]}; size 0/1/2/3 = B/H/W/D
//  ex_st_data       in   XLEN   store source, LSB-aligned
//  mem_valid_out    out  1      MEM->WB valid
//  wb_allow_in      in   1      WB accepts
//  mem_to_wb_bus_o  out  BUS_W  WB payload; wdata replaced by load data for loads
//  flush            in   1      WB exception/trap flush (|exc_op at WB)
//  data_req         out  1      data access request
//  data_we          out  1      1 = store
//  data_addr        out  XLEN   byte address, unmodified effective address
//  data_size        out  2      access size
//  data_wdata       out  XLEN   store data, lane-shifted
//  data_wstrb       out  8      byte strobes, 0 for loads
//  data_ack         in   1      one-cycle completion pulse
//  data_rdata       in   XLEN   full 64-bit aligned doubleword, valid with data_ack
//  MEM_wdest        out  5      forwarding dest; 0 when the stage is empty
//  MEM_result       out  XLEN   forwarding value
//  MEM_ld_pending   out  1      valid load whose data is not yet captured; EX uses it for load-use stall
// BEHAVIOUR
//  Reset (rst=0, async)
//   - mem_valid=0, state=IDLE, pipeline register cleared, data_req=0.
//   - All outputs 0.
//  Accept
//   - mem_allow_in = state!=DRAIN && (!mem_valid || (mem_ready_go && wb_allow_in)).
//   - Register loads on ex_valid_out && mem_allow_in.
//   - mem_valid <= ex_valid_out whenever mem_allow_in; flush forces mem_valid <= 0 and has priority.
//  Access qualification
//   - access = mem_valid && (is_load|is_store) && exc_op==0 && !exc_type[63].
//   - Any instruction that is not an access has mem_ready_go=1 and passes through in 1 cycle.
//  FSM
//   - IDLE -> REQ when access.
//   - REQ: data_req=1, all data_* fields held stable; on data_ack capture formatted data -> DONE.
//     A flush in REQ without data_ack -> DRAIN.
//   - DONE: mem_ready_go=1; on wb_allow_in or flush -> IDLE.
//   - DRAIN: data_req stays 1 until data_ack; the response is discarded -> IDLE; mem_allow_in=0 meanwhile.
//   - A flush in REQ together with data_ack -> IDLE, data discarded.
//  Latency
//   - Access with ack in cycle N: mem_valid_out=1 in cycle N+1.
//   - Minimum 2 cycles in stage; non-access instructions 1 cycle.
//  Store formatting (off = addr[2:0])
//   - data_wdata = st_data << (8*off).
//   - data_wstrb = ((1<<(1<<size))-1) << off, truncated to 8 bits.
//   - Misalignment is EX's exception; no check is made here.
//  Load formatting
//   - r = rdata >> (8*off); keep the low 8/16/32/64 bits.
//   - Sign- or zero-extend per the unsigned bit. Stores and non-loads keep the ALU wdata.
//  Outputs
//   - mem_valid_out = mem_valid && mem_ready_go && !flush.
//   - MEM_wdest = wdest & {5{mem_valid}}.
//   - MEM_result = wdata (load data once in DONE).
//   - MEM_ld_pending = mem_valid && is_load && state!=DONE.
// TESTING
//  1. ADD-type, wen=1, wdest=5, wdata=0x1234, wb_allow_in=1 -> mem_valid_out next cycle, bus identical to input.
//  2. LB unsigned=0, addr=0x8000_0003, rdata=0x0000_0000_8000_0000, ack after 3 cycles
//     -> wstrb=0, wdata=0xFFFF_FFFF_FFFF_FF80, mem_valid_out in the cycle after ack.
//  3. SH addr=0x...6, st_data=0xBEEF -> data_wdata=0xBEEF_0000_0000_0000, data_wstrb=0xC0, data_we=1.
//  4. Load in REQ, flush pulse, ack 2 cycles later -> req held until ack, mem_valid_out stays 0,
//     mem_allow_in=0 until IDLE.
//  5. Load in DONE, wb_allow_in=0 for 4 cycles -> mem_valid_out held, bus stable, mem_allow_in=0, no second req.
//  6. Load with exc_op!=0 -> data_req never asserted; passes to WB in 1 cycle. Reset mid-REQ -> all outputs 0 immediately.

Source files
------------

// File: rtl/ysyx_210247_mem_stage.sv
// ysyx_210247_mem_stage
//   Memory-access pipeline stage between EX and WB. Holds one instruction,
//   issues at most one load/store on a req/ack data port, formats load data
//   and presents the result on the MEM->WB bus and the MEM forwarding path.
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   ex_valid_out/mem_allow_in   EX->MEM handshake
//   ex_to_mem_bus, ex_mem_op, ex_st_data   EX payload, access op, store source
//   mem_valid_out/wb_allow_in   MEM->WB handshake
//   mem_to_wb_bus_o          WB payload (wdata replaced by load data for loads)
//   flush                    kill the instruction held in this stage
//   data_req/we/addr/size/wdata/wstrb, data_ack/rdata   data memory port
//   MEM_wdest, MEM_result, MEM_ld_pending   forwarding / load-use interface
module ysyx_210247_mem_stage #(
  parameter int XLEN  = 64,
  parameter int BUS_W = 403
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid_out,
  output logic             mem_allow_in,
  input  logic [BUS_W-1:0] ex_to_mem_bus,
  input  logic [4:0]       ex_mem_op,
  input  logic [XLEN-1:0]  ex_st_data,
  output logic             mem_valid_out,
  input  logic             wb_allow_in,
  output logic [BUS_W-1:0] mem_to_wb_bus_o,
  input  logic             flush,
  output logic             data_req,
  output logic             data_we,
  output logic [XLEN-1:0]  data_addr,
  output logic [1:0]       data_size,
  output logic [XLEN-1:0]  data_wdata,
  output logic [7:0]       data_wstrb,
  input  logic             data_ack,
  input  logic [XLEN-1:0]  data_rdata,
  output logic [4:0]       MEM_wdest,
  output logic [XLEN-1:0]  MEM_result,
  output logic             MEM_ld_pending
);

  // Bus field positions (wdata at the LSB end, exc_type at the MSB end).
  localparam int WDEST_LSB  = XLEN;
  localparam int EXC_OP_LSB = BUS_W - 64 - 64 - 32;

  typedef enum logic [1:0] {IDLE, REQ, DONE, DRAIN} state_t;

  state_t            state, state_nxt;
  logic              mem_valid;
  logic [BUS_W-1:0]  bus_p1;
  logic [4:0]        op_p1;
  logic [XLEN-1:0]   st_p1;
  logic [XLEN-1:0]   ld_data_p1;

  logic              access, in_access, mem_ready_go, allow_in;
  logic [2:0]        off;
  logic [XLEN-1:0]   result;

  function automatic logic [7:0] store_strb(input logic [1:0] size, input logic [2:0] sh);
    logic [7:0] m;
    case (size)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << sh;  // lanes past byte 7 fall off
  endfunction

  function automatic logic [XLEN-1:0] fmt_load(input logic [XLEN-1:0] rdata,
                                               input logic [4:0] op,
                                               input logic [2:0] sh);
    logic [XLEN-1:0]    r;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    logic [XLEN-1:0]    res;
    r = rdata >> {sh, 3'b000};
    b = r[7:0];
    h = r[15:0];
    w = r[31:0];
    case (op[1:0])
      2'd0:    if (op[2]) res = XLEN'(r[7:0]);  else res = XLEN'(b);
      2'd1:    if (op[2]) res = XLEN'(r[15:0]); else res = XLEN'(h);
      2'd2:    if (op[2]) res = XLEN'(r[31:0]); else res = XLEN'(w);
      default: res = r;
    endcase
    return res;
  endfunction

  assign off    = bus_p1[2:0];
  assign access = mem_valid && (op_p1[4] | op_p1[3]) &&
                  (bus_p1[EXC_OP_LSB +: 32] == 32'd0) && !bus_p1[BUS_W-1];

  assign mem_ready_go = !access || (state == DONE);
  assign allow_in     = (state != DRAIN) && (!mem_valid || (mem_ready_go && wb_allow_in));
  // Held low while reset is asserted so every output reads 0 during reset.
  assign mem_allow_in = allow_in && rst;

  // An accepted access goes straight to REQ so the request is issued in its
  // first cycle in the stage (2-cycle minimum residency).
  assign in_access = ex_valid_out && allow_in && !flush && (ex_mem_op[4] | ex_mem_op[3]) &&
                     (ex_to_mem_bus[EXC_OP_LSB +: 32] == 32'd0) && !ex_to_mem_bus[BUS_W-1];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (in_access) state_nxt = REQ;
      REQ: begin
        if (data_ack && flush) state_nxt = IDLE;
        else if (data_ack)     state_nxt = DONE;
        else if (flush)        state_nxt = DRAIN;
      end
      DONE: begin
        if (flush)            state_nxt = IDLE;
        else if (wb_allow_in) state_nxt = in_access ? REQ : IDLE;
      end
      DRAIN: if (data_ack) state_nxt = IDLE;  // response is discarded
      default: state_nxt = IDLE;
    endcase
  end

  // Stage boundary: EX -> MEM pipeline register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      mem_valid  <= 1'b0;
      bus_p1     <= '0;
      op_p1      <= '0;
      st_p1      <= '0;
      ld_data_p1 <= '0;
    end else begin
      state <= state_nxt;
      if (flush)         mem_valid <= 1'b0;
      else if (allow_in) mem_valid <= ex_valid_out;
      if (ex_valid_out && allow_in) begin
        bus_p1 <= ex_to_mem_bus;
        op_p1  <= ex_mem_op;
        st_p1  <= ex_st_data;
      end
      if (state == REQ && data_ack) ld_data_p1 <= fmt_load(data_rdata, op_p1, off);
    end
  end

  assign data_req   = (state == REQ) || (state == DRAIN);
  assign data_we    = data_req && op_p1[3];
  assign data_addr  = bus_p1[XLEN-1:0];
  assign data_size  = op_p1[1:0];
  assign data_wdata = st_p1 << {off, 3'b000};
  assign data_wstrb = op_p1[3] ? store_strb(op_p1[1:0], off) : 8'h00;

  assign result = (state == DONE && op_p1[4]) ? ld_data_p1 : bus_p1[XLEN-1:0];

  assign mem_valid_out   = mem_valid && mem_ready_go && !flush;
  assign mem_to_wb_bus_o = {bus_p1[BUS_W-1:XLEN], result};
  assign MEM_wdest       = bus_p1[WDEST_LSB +: 5] & {5{mem_valid}};
  assign MEM_result      = result;
  assign MEM_ld_pending  = mem_valid && op_p1[4] && (state != DONE);

endmodule

// File: tb/tb_ysyx_210247_mem_stage.sv
module tb_ysyx_210247_mem_stage;
  localparam int XLEN  = 64;
  localparam int BUS_W = 403;

  logic             clk = 1'b0;
  logic             rst;
  logic             ex_valid_out;
  logic             mem_allow_in;
  logic [BUS_W-1:0] ex_to_mem_bus;
  logic [4:0]       ex_mem_op;
  logic [XLEN-1:0]  ex_st_data;
  logic             mem_valid_out;
  logic             wb_allow_in;
  logic [BUS_W-1:0] mem_to_wb_bus_o;
  logic             flush;
  logic             data_req;
  logic             data_we;
  logic [XLEN-1:0]  data_addr;
  logic [1:0]       data_size;
  logic [XLEN-1:0]  data_wdata;
  logic [7:0]       data_wstrb;
  logic             data_ack;
  logic [XLEN-1:0]  data_rdata;
  logic [4:0]       MEM_wdest;
  logic [XLEN-1:0]  MEM_result;
  logic             MEM_ld_pending;

  ysyx_210247_mem_stage #(.XLEN(XLEN), .BUS_W(BUS_W)) dut (
    .clk(clk), .rst(rst), .ex_valid_out(ex_valid_out), .mem_allow_in(mem_allow_in),
    .ex_to_mem_bus(ex_to_mem_bus), .ex_mem_op(ex_mem_op), .ex_st_data(ex_st_data),
    .mem_valid_out(mem_valid_out), .wb_allow_in(wb_allow_in), .mem_to_wb_bus_o(mem_to_wb_bus_o),
    .flush(flush), .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_size(data_size), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_ack(data_ack), .data_rdata(data_rdata), .MEM_wdest(MEM_wdest),
    .MEM_result(MEM_result), .MEM_ld_pending(MEM_ld_pending)
  );

  always #5 clk = ~clk;

  // op = {is_load, is_store, unsigned, size}
  localparam logic [4:0] OP_LB = 5'b10000, OP_LBU = 5'b10100, OP_LH = 5'b10001, OP_LHU = 5'b10101;
  localparam logic [4:0] OP_LW = 5'b10010, OP_LWU = 5'b10110, OP_LD = 5'b10011;
  localparam logic [4:0] OP_SB = 5'b01000, OP_SH = 5'b01001, OP_SW = 5'b01010, OP_SD = 5'b01011;

  typedef struct {
    logic [4:0]  op;
    logic [63:0] addr;
    logic [63:0] st;
    logic [63:0] rdata;
    logic [63:0] exp_wdata;
    logic [7:0]  exp_strb;
    logic [63:0] exp_res;
  } vec_t;

  vec_t vt[12];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [BUS_W-1:0] mk_bus(input logic [63:0] wdata, input logic [4:0] wdest,
                                              input logic [31:0] exc_op, input logic exc63);
    logic [BUS_W-1:0] b;
    b = '0;
    b[63:0]    = wdata;
    b[68:64]   = wdest;
    b[69]      = 1'b1;
    b[101:70]  = 32'h0030_0513;
    b[165:102] = 64'h0000_0000_8000_1000;
    b[229:166] = 64'hC5C5_0000_1111_2222;
    b[241:230] = 12'h305;
    b[242]     = 1'b1;
    b[274:243] = exc_op;
    b[338:275] = 64'h0000_0000_0000_0ABC;
    b[402]     = exc63;
    return b;
  endfunction

  task automatic chk(input string nm, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic enter(input logic [BUS_W-1:0] b, input logic [4:0] op, input logic [63:0] st);
    ex_valid_out  = 1'b1;
    ex_to_mem_bus = b;
    ex_mem_op     = op;
    ex_st_data    = st;
    #2;
    chk("allow_in_empty", mem_allow_in, 1);
    tick;
    ex_valid_out  = 1'b0;
  endtask

  logic [BUS_W-1:0] b, eb;

  initial begin
    vt[0]  = '{OP_SH,  64'h8000_0006, 64'hBEEF,                  64'h0, 64'hBEEF_0000_0000_0000, 8'hC0, 64'h8000_0006};
    vt[1]  = '{OP_LB,  64'h8000_0003, 64'h0, 64'h0000_0000_8000_0000, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FF80};
    vt[2]  = '{OP_LBU, 64'h8000_0003, 64'h0, 64'h0000_0000_8000_0000, 64'h0, 8'h00, 64'h0000_0000_0000_0080};
    vt[3]  = '{OP_LH,  64'h8000_0002, 64'h0, 64'h0000_0000_F00D_0000, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_F00D};
    vt[4]  = '{OP_LHU, 64'h8000_0002, 64'h0, 64'h0000_0000_F00D_0000, 64'h0, 8'h00, 64'h0000_0000_0000_F00D};
    vt[5]  = '{OP_LW,  64'h8000_0004, 64'h0, 64'h8765_4321_0000_0000, 64'h0, 8'h00, 64'hFFFF_FFFF_8765_4321};
    vt[6]  = '{OP_LWU, 64'h8000_0004, 64'h0, 64'h8765_4321_0000_0000, 64'h0, 8'h00, 64'h0000_0000_8765_4321};
    vt[7]  = '{OP_LD,  64'h8000_0000, 64'h0, 64'h0123_4567_89AB_CDEF, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF};
    vt[8]  = '{OP_SB,  64'h8000_0005, 64'h1122_3344_5566_77AA, 64'h0, 64'h6677_AA00_0000_0000, 8'h20, 64'h8000_0005};
    vt[9]  = '{OP_SW,  64'h8000_0004, 64'hDEAD_BEEF,             64'h0, 64'hDEAD_BEEF_0000_0000, 8'hF0, 64'h8000_0004};
    vt[10] = '{OP_SD,  64'h8000_0000, 64'h0123_4567_89AB_CDEF,   64'h0, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h8000_0000};
    vt[11] = '{OP_SW,  64'h8000_0006, 64'hCAFE_F00D,             64'h0, 64'hF00D_0000_0000_0000, 8'hC0, 64'h8000_0006};

    rst = 1'b0; ex_valid_out = 1'b0; ex_to_mem_bus = '0; ex_mem_op = '0; ex_st_data = '0;
    wb_allow_in = 1'b1; flush = 1'b0; data_ack = 1'b0; data_rdata = '0;

    // Reset state
    tick; tick;
    chk("rst_valid_out", mem_valid_out, 0);
    chk("rst_allow_in", mem_allow_in, 0);
    chk("rst_req", data_req, 0);
    chk("rst_bus", mem_to_wb_bus_o, 0);
    chk("rst_wdest", MEM_wdest, 0);
    rst = 1'b1;
    tick;
    chk("post_rst_allow_in", mem_allow_in, 1);

    // ADD pass-through: one cycle in stage, bus unchanged
    b = mk_bus(64'h1234, 5'd5, 32'd0, 1'b0);
    enter(b, 5'b00000, 64'h0);
    #2;
    chk("add_valid_out", mem_valid_out, 1);
    chk("add_bus", mem_to_wb_bus_o, b);
    chk("add_wdest", MEM_wdest, 5);
    chk("add_result", MEM_result, 64'h1234);
    chk("add_no_req", data_req, 0);
    tick;
    #2;
    chk("add_gone", mem_valid_out, 0);
    chk("add_wdest_empty", MEM_wdest, 0);
    tick;

    // Table-driven load/store formatting
    for (int i = 0; i < 12; i++) begin
      b = mk_bus(vt[i].addr, 5'd10, 32'd0, 1'b0);
      enter(b, vt[i].op, vt[i].st);
      #2;
      chk("vec_req", data_req, 1);
      chk("vec_we", data_we, vt[i].op[3]);
      chk("vec_addr", data_addr, vt[i].addr);
      chk("vec_size", data_size, vt[i].op[1:0]);
      chk("vec_wdata", data_wdata, vt[i].exp_wdata);
      chk("vec_wstrb", data_wstrb, vt[i].exp_strb);
      chk("vec_wait_valid", mem_valid_out, 0);
      chk("vec_pending", MEM_ld_pending, vt[i].op[4]);
      data_ack = 1'b1; data_rdata = vt[i].rdata;
      tick;
      data_ack = 1'b0; data_rdata = '0;
      #2;
      eb = b; eb[63:0] = vt[i].exp_res;
      chk("vec_valid_out", mem_valid_out, 1);
      chk("vec_bus", mem_to_wb_bus_o, eb);
      chk("vec_result", MEM_result, vt[i].exp_res);
      chk("vec_pending_done", MEM_ld_pending, 0);
      chk("vec_req_done", data_req, 0);
      tick;
    end

    // LB with ack three cycles after request
    b = mk_bus(64'h8000_0003, 5'd7, 32'd0, 1'b0);
    enter(b, OP_LB, 64'h0);
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("lb_wait_req", data_req, 1);
      chk("lb_wait_valid", mem_valid_out, 0);
      chk("lb_wait_allow", mem_allow_in, 0);
      tick;
    end
    data_ack = 1'b1; data_rdata = 64'h0000_0000_8000_0000;
    tick;
    data_ack = 1'b0;
    #2;
    chk("lb_late_valid", mem_valid_out, 1);
    chk("lb_late_result", MEM_result, 64'hFFFF_FFFF_FFFF_FF80);
    tick;

    // Flush in REQ, ack two cycles later: drain
    b = mk_bus(64'h8000_0008, 5'd9, 32'd0, 1'b0);
    enter(b, OP_LD, 64'h0);
    #2;
    chk("fl_req", data_req, 1);
    flush = 1'b1;
    #1;
    chk("fl_valid_out", mem_valid_out, 0);
    tick;
    flush = 1'b0;
    #2;
    chk("drain_req", data_req, 1);
    chk("drain_allow", mem_allow_in, 0);
    chk("drain_valid_out", mem_valid_out, 0);
    chk("drain_wdest", MEM_wdest, 0);
    tick;
    #2;
    chk("drain_req2", data_req, 1);
    chk("drain_allow2", mem_allow_in, 0);
    data_ack = 1'b1; data_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick;
    data_ack = 1'b0;
    #2;
    chk("drain_end_req", data_req, 0);
    chk("drain_end_allow", mem_allow_in, 1);
    chk("drain_end_valid", mem_valid_out, 0);
    tick;

    // Flush together with ack in REQ: straight back to IDLE
    enter(b, OP_LD, 64'h0);
    flush = 1'b1; data_ack = 1'b1; data_rdata = 64'h5555;
    tick;
    flush = 1'b0; data_ack = 1'b0;
    #2;
    chk("flack_req", data_req, 0);
    chk("flack_allow", mem_allow_in, 1);
    chk("flack_valid", mem_valid_out, 0);
    chk("flack_pending", MEM_ld_pending, 0);
    tick;

    // DONE with WB stalled for 4 cycles
    wb_allow_in = 1'b0;
    b = mk_bus(64'h8000_0004, 5'd12, 32'd0, 1'b0);
    eb = b; eb[63:0] = 64'hFFFF_FFFF_8765_4321;
    enter(b, OP_LW, 64'h0);
    data_ack = 1'b1; data_rdata = 64'h8765_4321_0000_0000;
    tick;
    data_ack = 1'b0; data_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("stall_valid", mem_valid_out, 1);
      chk("stall_bus", mem_to_wb_bus_o, eb);
      chk("stall_allow", mem_allow_in, 0);
      chk("stall_no_req", data_req, 0);
      tick;
    end
    wb_allow_in = 1'b1;
    #2;
    chk("stall_release_allow", mem_allow_in, 1);
    tick;
    #2;
    chk("stall_gone", mem_valid_out, 0);
    tick;

    // Load carrying an exception: no request, one cycle through
    b = mk_bus(64'h8000_0010, 5'd3, 32'd2, 1'b0);
    enter(b, OP_LD, 64'h0);
    #2;
    chk("exc_no_req", data_req, 0);
    chk("exc_valid_out", mem_valid_out, 1);
    chk("exc_bus", mem_to_wb_bus_o, b);
    tick;
    #2;
    chk("exc_gone", mem_valid_out, 0);
    chk("exc_no_req2", data_req, 0);
    tick;

    // Reset while in REQ
    b = mk_bus(64'h8000_0018, 5'd4, 32'd0, 1'b0);
    enter(b, OP_LD, 64'h0);
    #2;
    chk("mrst_req_before", data_req, 1);
    rst = 1'b0;
    #1;
    chk("mrst_req", data_req, 0);
    chk("mrst_allow", mem_allow_in, 0);
    chk("mrst_valid", mem_valid_out, 0);
    chk("mrst_bus", mem_to_wb_bus_o, 0);
    chk("mrst_addr", data_addr, 0);
    chk("mrst_wdest", MEM_wdest, 0);
    chk("mrst_pending", MEM_ld_pending, 0);
    tick;
    rst = 1'b1;
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
